lock_manager: RTL and testbench
===============================

Name: lock_manager

Overview:
- Clocked, synthesizable resource-lock manager. Shares NRES lockable resources among NREQ requesters.
- All-or-nothing allocation: a requester is granted all the resources it asks for in the same cycle, or none of them. This removes the hold-and-wait deadlock that arises when two units each acquire one resource of a pair.
- A per-requester wait watchdog aborts requests that stay ungranted too long.
- Sits between requester units and the shared resources, replacing the per-resource two-input arbiters.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NRES, 2, number of lockable resources (1..8).
- TIMEOUT, 17, maximum cycles a requester may spend in WAIT before abort (>=2).
- CW, $clog2(TIMEOUT+1), wait-counter width (derived; not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NREQ*NRES  request masks; bit i*NRES+r = requester i wants resource r.
- gnt  output  NREQ  gnt[i]=1 while requester i holds every resource in its latched mask.
- abort  output  NREQ  one-cycle pulse when requester i's wait times out.
- busy  output  NRES  busy[r]=1 while resource r is held by any requester.

Behaviour:
- Reset: all requesters IDLE; gnt=0, abort=0, busy=0, rr_ptr=0, wait counters=0, held masks=0.
- Requester FSM (one per requester), with m_i = live REQ slice:
  - IDLE: m_i!=0 -> WAIT, counter cleared.
  - WAIT: m_i==0 -> IDLE (request withdrawn, no abort). Selected by arbiter -> HOLD, latch held_i=m_i. Otherwise, counter==TIMEOUT-1 -> BACKOFF. Otherwise counter+1.
  - HOLD: gnt[i]=1. m_i==0 -> IDLE, release held_i. Any nonzero change of m_i while in HOLD is ignored; held_i is unchanged.
  - BACKOFF: abort[i] pulses on the entry cycle only. Stay until m_i==0, then IDLE. The requester must drop REQ before it can request again.
- Free vector: free = ~OR(held_i over requesters in HOLD), computed from registered state. A resource released at edge k is grantable in the decision made at edge k+1, never at edge k.
- Arbitration, combinational over WAIT requesters with m_i!=0:
  - Scan from rr_ptr upward, wrapping modulo NREQ.
  - Select a requester if (m_i & ~free)==0 and m_i is disjoint from masks already selected this cycle.
  - Several disjoint requesters may be granted in the same cycle.
- rr_ptr: on any grant, rr_ptr <= (index of first selected in scan order)+1 mod NREQ. With no grant, rr_ptr is unchanged.
- Latency: REQ sampled nonzero at edge 1 -> WAIT; earliest gnt high after edge 2. Minimum request-to-grant is 2 cycles.
- gnt falls 1 cycle after REQ drops to 0. busy bits clear on the same edge.
- Simultaneous grant and timeout on the same edge: the grant wins and no abort is issued.
- All outputs are registered. busy[r] == OR over i of (gnt[i] & held_i[r]).
- Invariant: no resource held by two requesters. The bench asserts this every cycle.
- RST asserted mid-operation: at the next edge, all grants and busy bits drop and any pending abort is suppressed.

Decomposition:
- Package lock_pkg:
  - FSM state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_HOLD=2'd2, ST_BACKOFF=2'd3.
  - Index helper function for the REQ slice (i*NRES+r).
- One sub-module lock_slot, instantiated NREQ times: per-requester FSM, wait counter, held-mask register and gnt/abort flops.
- lock_manager holds the free-vector reduction, round-robin scan and rr_ptr.

Test Plan:
- Single grant: NREQ=2, NRES=2. REQ[1:0]=2'b11 from cycle 0 -> gnt[0]=1 at cycle 2, busy=2'b11. Drop REQ at cycle 5 -> gnt[0]=0, busy=0 at cycle 6.
- Disjoint parallel: r0 asks 2'b01, r1 asks 2'b10 on the same cycle -> gnt=2'b11 on the same cycle, busy=2'b11.
- Crossing contention, deadlock case: r0 and r1 both ask 2'b11 on the same cycle, rr_ptr=0 -> r0 granted, r1 WAIT, rr_ptr=1. r0 releases at cycle 6 -> r1 granted at cycle 8, never a partial grant.
- Watchdog: r0 holds 2'b11 indefinitely, r1 asks 2'b01 at cycle 3 -> r1 WAIT from cycle 4, abort[1] pulses exactly 1 cycle after 17 WAIT cycles. r1 stays in BACKOFF until its REQ=0, and is then re-grantable.
- Grant/timeout tie: r0 releases on the edge where r1's counter reaches TIMEOUT-1 -> r1 stays WAIT, granted on the next edge, abort[1] never pulses.
- Reset mid-hold: RST=1 for 1 cycle while gnt=2'b01 -> next edge gnt=0, busy=0, abort=0, rr_ptr=0. With REQ held, re-grant 2 cycles after RST falls.

Source files
------------

// File: rtl/lock_pkg.sv
// -----------------------------------------------------------------------------
// lock_pkg
// Shared definitions for the resource-lock manager.
//   lock_state_e : per-requester FSM encoding (IDLE / WAIT / HOLD / BACKOFF)
//   req_idx()    : flat bit position of (requester i, resource r) in the packed
//                  request vector, i*NRES + r
// -----------------------------------------------------------------------------
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_BACKOFF = 2'd3
    } lock_state_e;

    function automatic int req_idx(input int i, input int r, input int nres);
        return i * nres + r;
    endfunction

endpackage

// File: rtl/lock_slot.sv
// -----------------------------------------------------------------------------
// lock_slot
// Per-requester lock FSM: wait watchdog, latched held mask, registered
// gnt/abort flags.
//
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   mask_i    : live request mask of this requester (NRES bits)
//   sel_i     : arbiter picked this requester in the current cycle
//   state_o   : registered FSM state
//   held_o    : registered mask of resources this requester holds (0 if none)
//   claim_d_o : resources this requester will hold after the next edge
//   gnt_o     : registered, high while in HOLD
//   abort_o   : registered one-cycle pulse on entry to BACKOFF
// -----------------------------------------------------------------------------
module lock_slot
    import lock_pkg::*;
#(
    parameter int NRES    = 2,
    parameter int TIMEOUT = 17,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NRES-1:0] mask_i,
    input  logic            sel_i,
    output lock_state_e     state_o,
    output logic [NRES-1:0] held_o,
    output logic [NRES-1:0] claim_d_o,
    output logic            gnt_o,
    output logic            abort_o
);

    lock_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NRES-1:0] held_q, held_d;
    logic            gnt_q, gnt_d;
    logic            abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mask_i != '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                // Withdrawal beats everything; a grant beats the watchdog
                // expiring on the same edge.
                if (mask_i == '0) begin
                    state_d = ST_IDLE;
                end else if (sel_i) begin
                    state_d = ST_HOLD;
                    held_d  = mask_i;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_BACKOFF;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                // A nonzero change of the mask while holding is ignored; only
                // dropping the whole request releases the resources.
                if (mask_i == '0) begin
                    state_d = ST_IDLE;
                    held_d  = '0;
                end
            end
            ST_BACKOFF: begin
                // The requester must drop its request before retrying.
                if (mask_i == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                held_d  = '0;
            end
        endcase
    end

    assign gnt_d     = (state_d == ST_HOLD);
    assign claim_d_o = gnt_d ? held_d : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
            gnt_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            gnt_q   <= gnt_d;
            abort_q <= abort_d;
        end
    end

    assign state_o = state_q;
    assign held_o  = held_q;
    assign gnt_o   = gnt_q;
    assign abort_o = abort_q;

endmodule

// File: rtl/lock_manager.sv
// -----------------------------------------------------------------------------
// lock_manager
// All-or-nothing resource-lock manager: NREQ requesters share NRES resources.
// A requester receives every resource in its mask in one cycle or none of
// them, which removes hold-and-wait deadlock. A per-requester watchdog aborts
// requests left waiting too long.
//
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   REQ   : request masks, bit i*NRES+r = requester i wants resource r
//   gnt   : gnt[i] high while requester i holds its latched mask
//   abort : one-cycle pulse when requester i's wait times out
//   busy  : busy[r] high while resource r is held by any requester
// -----------------------------------------------------------------------------
module lock_manager
    import lock_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NRES    = 2,
    parameter int TIMEOUT = 17
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ*NRES-1:0] REQ,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      abort,
    output logic [NRES-1:0]      busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NRES-1:0] m        [NREQ];
    lock_state_e     state    [NREQ];
    logic [NRES-1:0] held     [NREQ];
    logic [NRES-1:0] claim_d  [NREQ];
    logic [NREQ-1:0] sel;
    logic [NRES-1:0] occupied;
    logic [NRES-1:0] free_res;
    logic [NRES-1:0] taken;
    logic            any_sel;
    logic [PW-1:0]   first_idx;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NRES-1:0] busy_q, busy_d;

    // Unpack the flat request vector into per-requester masks.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            for (int r = 0; r < NRES; r++) begin
                m[i][r] = REQ[req_idx(i, r, NRES)];
            end
        end
    end

    // Free vector from registered state only: a resource released on this
    // edge is not visible as free until the following decision.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (state[i] == ST_HOLD) begin
                occupied = occupied | held[i];
            end
        end
        free_res = ~occupied;
    end

    // Round-robin scan starting at rr_q. A waiting requester is picked when
    // all of its resources are free and none was already claimed by an
    // earlier pick in this same scan, so disjoint requesters share a cycle.
    always_comb begin
        sel       = '0;
        taken     = '0;
        any_sel   = 1'b0;
        first_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if ((state[idx] == ST_WAIT) && (m[idx] != '0) &&
                ((m[idx] & ~free_res) == '0) && ((m[idx] & taken) == '0)) begin
                sel[idx] = 1'b1;
                taken    = taken | m[idx];
                if (!any_sel) begin
                    any_sel   = 1'b1;
                    first_idx = PW'(idx);
                end
            end
        end
    end

    // Pointer moves just past the first requester granted in scan order.
    always_comb begin
        rr_d = rr_q;
        if (any_sel) begin
            rr_d = (first_idx == PW'(NREQ - 1)) ? '0 : first_idx + PW'(1);
        end
    end

    always_comb begin
        busy_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy_d = busy_d | claim_d[i];
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        lock_slot #(
            .NRES    (NRES),
            .TIMEOUT (TIMEOUT),
            .CW      (CW)
        ) u_slot (
            .clk_i     (CLK),
            .rst_i     (RST),
            .mask_i    (m[g]),
            .sel_i     (sel[g]),
            .state_o   (state[g]),
            .held_o    (held[g]),
            .claim_d_o (claim_d[g]),
            .gnt_o     (gnt[g]),
            .abort_o   (abort[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_q   <= '0;
            busy_q <= '0;
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_lock_manager.sv
module tb_lock_manager;

    localparam int NREQ    = 2;
    localparam int NRES    = 2;
    localparam int TIMEOUT = 17;
    localparam int ALL     = (1 << NRES) - 1;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ*NRES-1:0] REQ;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      abort;
    logic [NRES-1:0]      busy;

    int n_checks = 0;
    int n_errors = 0;

    lock_manager #(
        .NREQ    (NREQ),
        .NRES    (NRES),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .REQ   (REQ),
        .gnt   (gnt),
        .abort (abort),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Reference model: each requester is described by how long it has been
    // waiting (-1 = not waiting), what it currently holds (0 = nothing) and
    // whether it is sitting out after a timeout.
    int m_age  [NREQ];
    int m_hold [NREQ];
    bit m_back [NREQ];
    int m_rr;
    int e_gnt, e_abort, e_busy;

    function automatic int mask_of(input int i);
        return (int'(REQ) >> (i * NRES)) & ALL;
    endfunction

    task automatic model_step();
        int freem, taken, first, mk, i;
        bit win [NREQ];
        if (RST) begin
            for (int j = 0; j < NREQ; j++) begin
                m_age[j] = -1; m_hold[j] = 0; m_back[j] = 1'b0;
            end
            m_rr = 0; e_gnt = 0; e_abort = 0; e_busy = 0;
            return;
        end
        freem = ALL;
        for (int j = 0; j < NREQ; j++) begin
            freem = freem & ~m_hold[j];
            win[j] = 1'b0;
        end
        taken = 0;
        first = -1;
        for (int k = 0; k < NREQ; k++) begin
            i  = (m_rr + k) % NREQ;
            mk = mask_of(i);
            if (m_age[i] >= 0 && mk != 0 && (mk & ~freem & ALL) == 0 && (mk & taken) == 0) begin
                win[i] = 1'b1;
                taken  = taken | mk;
                if (first < 0) first = i;
            end
        end
        if (first >= 0) m_rr = (first + 1) % NREQ;
        e_gnt = 0; e_abort = 0; e_busy = 0;
        for (int j = 0; j < NREQ; j++) begin
            mk = mask_of(j);
            if (m_back[j]) begin
                if (mk == 0) m_back[j] = 1'b0;
            end else if (m_hold[j] != 0) begin
                if (mk == 0) m_hold[j] = 0;
            end else if (m_age[j] >= 0) begin
                if (mk == 0) m_age[j] = -1;
                else if (win[j]) begin
                    m_hold[j] = mk; m_age[j] = -1;
                end else if (m_age[j] == TIMEOUT - 1) begin
                    m_back[j] = 1'b1; m_age[j] = -1; e_abort = e_abort | (1 << j);
                end else m_age[j] = m_age[j] + 1;
            end else if (mk != 0) begin
                m_age[j] = 0;
            end
            if (m_hold[j] != 0) begin
                e_gnt  = e_gnt | (1 << j);
                e_busy = e_busy | m_hold[j];
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        model_step();
        chk("model.gnt", int'(gnt), e_gnt);
        chk("model.abort", int'(abort), e_abort);
        chk("model.busy", int'(busy), e_busy);
        if (gnt[0] && gnt[1]) begin
            chk("invariant.overlap", int'(dut.held[0] & dut.held[1]), 0);
        end
    endtask

    task automatic drive(input logic r, input logic [NREQ*NRES-1:0] q);
        RST = r;
        REQ = q;
        tick();
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [1:0] gnt;
        logic [1:0] abort;
        logic [1:0] busy;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    int n;
    int any_ab;

    initial begin
        // req = {r1[1:0], r0[1:0]}
        tbl[0]  = '{1'b1, 4'b0011, 2'b00, 2'b00, 2'b00}; // reset
        tbl[1]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b0, 4'b0011, 2'b00, 2'b00, 2'b00}; // r0 -> WAIT
        tbl[3]  = '{1'b0, 4'b0011, 2'b01, 2'b00, 2'b11}; // r0 granted
        tbl[4]  = '{1'b0, 4'b0011, 2'b01, 2'b00, 2'b11};
        tbl[5]  = '{1'b0, 4'b0011, 2'b01, 2'b00, 2'b11};
        tbl[6]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 2'b00}; // released
        tbl[7]  = '{1'b0, 4'b1001, 2'b00, 2'b00, 2'b00}; // disjoint, WAIT
        tbl[8]  = '{1'b0, 4'b1001, 2'b11, 2'b00, 2'b11}; // both granted
        tbl[9]  = '{1'b0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{1'b0, 4'b1111, 2'b00, 2'b00, 2'b00}; // crossing, WAIT
        tbl[11] = '{1'b0, 4'b1111, 2'b01, 2'b00, 2'b11}; // r0 wins (rr=0)
        tbl[12] = '{1'b0, 4'b1111, 2'b01, 2'b00, 2'b11};
        tbl[13] = '{1'b0, 4'b1100, 2'b00, 2'b00, 2'b00}; // r0 releases
        tbl[14] = '{1'b0, 4'b1100, 2'b10, 2'b00, 2'b11}; // r1 next edge
        tbl[15] = '{1'b0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[16] = '{1'b0, 4'b0001, 2'b00, 2'b00, 2'b00};
        tbl[17] = '{1'b0, 4'b0001, 2'b01, 2'b00, 2'b01};
        tbl[18] = '{1'b0, 4'b0011, 2'b01, 2'b00, 2'b01}; // change ignored
        tbl[19] = '{1'b0, 4'b1011, 2'b01, 2'b00, 2'b01}; // r1 -> WAIT
        tbl[20] = '{1'b0, 4'b1011, 2'b11, 2'b00, 2'b11}; // r1 gets r1 only
        tbl[21] = '{1'b0, 4'b0000, 2'b00, 2'b00, 2'b00};

        for (int j = 0; j < NREQ; j++) begin
            m_age[j] = -1; m_hold[j] = 0; m_back[j] = 1'b0;
        end
        m_rr = 0; e_gnt = 0; e_abort = 0; e_busy = 0;

        RST = 1'b1;
        REQ = '0;
        tick();
        tick();
        chk("reset.gnt", int'(gnt), 0);
        chk("reset.abort", int'(abort), 0);
        chk("reset.busy", int'(busy), 0);

        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].rst, tbl[v].req);
            chk($sformatf("vec%0d.gnt", v), int'(gnt), int'(tbl[v].gnt));
            chk($sformatf("vec%0d.abort", v), int'(abort), int'(tbl[v].abort));
            chk($sformatf("vec%0d.busy", v), int'(busy), int'(tbl[v].busy));
        end

        // Watchdog: r0 holds both, r1 waits for resource 0 until abort.
        drive(1'b0, 4'b0011);
        drive(1'b0, 4'b0011);
        chk("wd.hold", int'(gnt), 1);
        drive(1'b0, 4'b0111);
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            drive(1'b0, 4'b0111);
            if (abort[1]) begin
                n = c;
                break;
            end
        end
        chk("wd.latency", n, 17);
        chk("wd.abort_val", int'(abort), 2);
        drive(1'b0, 4'b0111);
        chk("wd.pulse_width", int'(abort), 0);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0100);
        chk("wd.backoff_no_gnt", int'(gnt), 0);
        drive(1'b0, 4'b0100);
        chk("wd.backoff_no_gnt2", int'(gnt), 0);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0100);
        drive(1'b0, 4'b0100);
        chk("wd.regrant", int'(gnt), 2);
        chk("wd.regrant_busy", int'(busy), 1);
        drive(1'b0, 4'b0000);

        // Grant/timeout tie: r0 releases on the edge r1's count reaches TIMEOUT-1.
        drive(1'b0, 4'b0011);
        drive(1'b0, 4'b0011);
        drive(1'b0, 4'b0111);
        any_ab = 0;
        for (int c = 0; c < TIMEOUT - 2; c++) begin
            drive(1'b0, 4'b0111);
            any_ab = any_ab | int'(abort);
        end
        drive(1'b0, 4'b0100);
        any_ab = any_ab | int'(abort);
        chk("tie.release", int'(gnt), 0);
        drive(1'b0, 4'b0100);
        any_ab = any_ab | int'(abort);
        chk("tie.grant", int'(gnt), 2);
        drive(1'b0, 4'b0100);
        any_ab = any_ab | int'(abort);
        chk("tie.no_abort", any_ab, 0);
        drive(1'b0, 4'b0000);

        // Reset mid-hold; rr_ptr must return to 0 so r0 wins the re-grant.
        drive(1'b0, 4'b0011);
        drive(1'b0, 4'b0011);
        chk("rst.pre_hold", int'(gnt), 1);
        drive(1'b1, 4'b1111);
        chk("rst.gnt", int'(gnt), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.abort", int'(abort), 0);
        drive(1'b0, 4'b1111);
        chk("rst.wait", int'(gnt), 0);
        drive(1'b0, 4'b1111);
        chk("rst.regrant", int'(gnt), 1);
        chk("rst.regrant_busy", int'(busy), 3);
        drive(1'b0, 4'b0000);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int nr;
            nr = int'(REQ);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    int nm;
                    nm = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, ALL));
                    nr = (nr & ~(ALL << (i * NRES))) | (nm << (i * NRES));
                end
            end
            RST = ($urandom_range(0, 199) == 0);
            REQ = (NREQ*NRES)'(nr);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
